// File: rtl/main_decoder_pipe.sv
// -----------------------------------------------------------------------------
// main_decoder_pipe
//
// RV32/RV64 main control decoder followed by a small output queue.
// Each accepted instruction is decoded combinationally from its opcode
// and pushed, together with the raw instruction word, into a FIFO of
// BUF_DEPTH entries. All outputs come from the queue head.
//
// A small FSM (RUN / DRAIN / HALT) stops intake after a trap entry
// (ECALL, EBREAK, or illegal when ILLEGAL_TRAP=1). It lets the queue
// drain up to and including that entry, then halts until i_flush.
//
// Parameters
//   XLEN         : 32 or 64. With 64, the W-opcodes (OP-IMM-32, OP-32) are legal.
//   BUF_DEPTH    : queue entries, 1, 2 or 4.
//   ILLEGAL_TRAP : 1 = an illegal instruction halts like ECALL, 0 = flag only.
//
// Configuration macro
//   ZICSR_EN     : when defined, SYSTEM with funct3 != 000 decodes as a CSR
//                  access (reg_we, result_src 101). When undefined it is illegal.
//
// Ports
//   i_clk, i_rstn           : clock and synchronous active-low reset
//   i_flush                 : redirect. Empties the queue and returns to RUN.
//   i_valid/o_ready/i_instr : upstream handshake and instruction word
//   o_valid/i_ready         : downstream handshake on the queue head
//   o_instr                 : instruction word of the head entry
//   o_imm_src, o_result_src, o_alu_op, o_forward_src, o_trap and 1-bit
//   control outputs         : decoded fields of the head entry
//   o_halted                : block is in HALT
// -----------------------------------------------------------------------------
module main_decoder_pipe #(
  parameter int XLEN         = 64,
  parameter int BUF_DEPTH    = 2,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [2:0]  o_imm_src,
  output logic [2:0]  o_result_src,
  output logic [2:0]  o_alu_op,
  output logic        o_mem_we,
  output logic        o_reg_we,
  output logic        o_alu_src,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_pc_target_src,
  output logic        o_mem_access,
  output logic        o_load_instr,
  output logic [1:0]  o_forward_src,
  output logic [1:0]  o_trap,
  output logic        o_halted
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ECALL   = 2'b01;
  localparam logic [1:0] TRAP_EBREAK  = 2'b10;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [2:0]  result_src;
    logic [2:0]  alu_op;
    logic        mem_we;
    logic        reg_we;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        pc_target_src;
    logic        mem_access;
    logic        load_instr;
    logic [1:0]  forward_src;
    logic [1:0]  trap;
  } entry_t;

  entry_t             dec;
  entry_t             head;
  entry_t             mem [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;
  logic               push;
  logic               pop;
  logic               dec_is_trap;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a default before the case so that no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dec       = '0;
    dec.instr = i_instr;
    case (i_instr[6:0])
      OPC_LOAD: begin
        dec.reg_we     = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'b001;
        dec.mem_access = 1'b1;
        dec.load_instr = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_we  = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_op  = 3'b010;
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          dec.reg_we  = 1'b1;
          dec.alu_src = 1'b1;
          dec.alu_op  = 3'b011;
        end else begin
          dec.trap = TRAP_ILLEGAL;
        end
      end
      OPC_JALR: begin
        dec.imm_src       = 3'b000;
        dec.reg_we        = 1'b1;
        dec.alu_src       = 1'b1;
        dec.jump          = 1'b1;
        dec.result_src    = 3'b010;
        dec.pc_target_src = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_src    = 3'b011;
        dec.reg_we     = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 3'b010;
      end
      OPC_STORE: begin
        dec.imm_src    = 3'b001;
        dec.mem_we     = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_access = 1'b1;
      end
      OPC_OP: begin
        dec.reg_we = 1'b1;
        dec.alu_op = 3'b010;
      end
      OPC_OP32: begin
        if (XLEN == 64) begin
          dec.reg_we = 1'b1;
          dec.alu_op = 3'b011;
        end else begin
          dec.trap = TRAP_ILLEGAL;
        end
      end
      OPC_BRANCH: begin
        dec.imm_src = 3'b010;
        dec.branch  = 1'b1;
        dec.alu_op  = 3'b001;
      end
      OPC_AUIPC: begin
        dec.imm_src     = 3'b100;
        dec.reg_we      = 1'b1;
        dec.result_src  = 3'b011;
        dec.forward_src = 2'b01;
      end
      OPC_LUI: begin
        dec.imm_src     = 3'b100;
        dec.reg_we      = 1'b1;
        dec.result_src  = 3'b100;
        dec.forward_src = 2'b10;
      end
      OPC_SYSTEM: begin
        if (i_instr == 32'h0000_0073) begin
          dec.trap = TRAP_ECALL;
        end else if (i_instr == 32'h0010_0073) begin
          dec.trap = TRAP_EBREAK;
        end
`ifdef ZICSR_EN
        else if (i_instr[14:12] != 3'b000) begin
          dec.reg_we     = 1'b1;
          dec.result_src = 3'b101;
        end
`endif
        else begin
          dec.trap = TRAP_ILLEGAL;
        end
      end
      // Any unlisted opcode, including words whose low bits are not 11.
      default: dec.trap = TRAP_ILLEGAL;
    endcase
  end

  // An entry that ends intake: ECALL/EBREAK always, illegal only if configured.
  always_comb begin
    dec_is_trap = (dec.trap == TRAP_ECALL) || (dec.trap == TRAP_EBREAK) ||
                  ((dec.trap == TRAP_ILLEGAL) && (ILLEGAL_TRAP != 0));
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign o_ready  = (state == ST_RUN) && (count < CNT_W'(BUF_DEPTH));
  assign o_valid  = (count != '0);
  assign o_halted = (state == ST_HALT);
  assign push     = i_valid && o_ready;
  assign pop      = o_valid && i_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset. An entry is only visible when count
  // covers it, and the outputs are zeroed otherwise, so clearing it buys nothing.
  always_ff @(posedge i_clk) begin
    if (push && i_rstn && !i_flush) begin
      mem[wr_ptr] <= dec;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and run/drain/halt FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      state  <= ST_RUN;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        ST_RUN:   if (push && dec_is_trap) state <= ST_DRAIN;
        // The trap entry is always the last in the queue, so popping the
        // final entry in DRAIN retires it.
        ST_DRAIN: if (pop && (count == CNT_W'(1))) state <= ST_HALT;
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, forced to zero when the queue is empty
  // ---------------------------------------------------------------------------
  assign head = o_valid ? mem[rd_ptr] : '0;

  assign o_instr         = head.instr;
  assign o_imm_src       = head.imm_src;
  assign o_result_src    = head.result_src;
  assign o_alu_op        = head.alu_op;
  assign o_mem_we        = head.mem_we;
  assign o_reg_we        = head.reg_we;
  assign o_alu_src       = head.alu_src;
  assign o_branch        = head.branch;
  assign o_jump          = head.jump;
  assign o_pc_target_src = head.pc_target_src;
  assign o_mem_access    = head.mem_access;
  assign o_load_instr    = head.load_instr;
  assign o_forward_src   = head.forward_src;
  assign o_trap          = head.trap;

endmodule

// File: tb/tb_main_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_main_decoder_pipe
//
// Directed bench for main_decoder_pipe. The instance "dut" has the default
// parameters (XLEN=64, BUF_DEPTH=2, ILLEGAL_TRAP=1). The instance "dut_w"
// has XLEN=32 and ILLEGAL_TRAP=0. Both share the same inputs.
// Inputs are driven 1 time unit after a rising edge, and outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_main_decoder_pipe;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        valid;
  logic [31:0] instr;
  logic        ready;

  // Default-parameter instance outputs
  logic        o_ready, o_valid, o_mem_we, o_reg_we, o_alu_src, o_branch, o_jump;
  logic        o_pc_target_src, o_mem_access, o_load_instr, o_halted;
  logic [31:0] o_instr;
  logic [2:0]  o_imm_src, o_result_src, o_alu_op;
  logic [1:0]  o_forward_src, o_trap;

  // XLEN=32 / ILLEGAL_TRAP=0 instance outputs
  logic        w_ready, w_valid, w_mem_we, w_reg_we, w_alu_src, w_branch, w_jump;
  logic        w_pc_target_src, w_mem_access, w_load_instr, w_halted;
  logic [31:0] w_instr;
  logic [2:0]  w_imm_src, w_result_src, w_alu_op;
  logic [1:0]  w_forward_src, w_trap;

  // Control vector: {imm_src, result_src, alu_op,
  //   mem_we, reg_we, alu_src, branch, jump, pc_target_src, mem_access, load_instr,
  //   forward_src, trap}
  logic [20:0] ctl, ctl_w;
  assign ctl   = {o_imm_src, o_result_src, o_alu_op, o_mem_we, o_reg_we, o_alu_src,
                  o_branch, o_jump, o_pc_target_src, o_mem_access, o_load_instr,
                  o_forward_src, o_trap};
  assign ctl_w = {w_imm_src, w_result_src, w_alu_op, w_mem_we, w_reg_we, w_alu_src,
                  w_branch, w_jump, w_pc_target_src, w_mem_access, w_load_instr,
                  w_forward_src, w_trap};

  int errors = 0;
  int checks = 0;

  main_decoder_pipe dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .o_valid(o_valid), .i_ready(ready), .o_instr(o_instr),
    .o_imm_src(o_imm_src), .o_result_src(o_result_src), .o_alu_op(o_alu_op),
    .o_mem_we(o_mem_we), .o_reg_we(o_reg_we), .o_alu_src(o_alu_src),
    .o_branch(o_branch), .o_jump(o_jump), .o_pc_target_src(o_pc_target_src),
    .o_mem_access(o_mem_access), .o_load_instr(o_load_instr),
    .o_forward_src(o_forward_src), .o_trap(o_trap), .o_halted(o_halted)
  );

  main_decoder_pipe #(.XLEN(32), .BUF_DEPTH(2), .ILLEGAL_TRAP(0)) dut_w (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(w_ready),
    .i_instr(instr), .o_valid(w_valid), .i_ready(ready), .o_instr(w_instr),
    .o_imm_src(w_imm_src), .o_result_src(w_result_src), .o_alu_op(w_alu_op),
    .o_mem_we(w_mem_we), .o_reg_we(w_reg_we), .o_alu_src(w_alu_src),
    .o_branch(w_branch), .o_jump(w_jump), .o_pc_target_src(w_pc_target_src),
    .o_mem_access(w_mem_access), .o_load_instr(w_load_instr),
    .o_forward_src(w_forward_src), .o_trap(w_trap), .o_halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; instr = '0;
    tick();
    tick();
    rstn = 1'b1;
    checks++;
    if ({o_valid, o_halted, o_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_hs got valid/halted/ready=%b want 001", {o_valid, o_halted, o_ready});
    end
    checks++;
    if (ctl !== 21'h0) begin
      errors++;
      $display("FAIL reset_ctl got %h want 000000", ctl);
    end
  endtask

  task automatic test_addi();
    test_reset();
    instr = 32'h00A00093; valid = 1'b1; ready = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if ({o_valid, o_instr} !== {1'b1, 32'h00A00093}) begin
      errors++;
      $display("FAIL addi_head got valid=%b instr=%h want 1 00a00093", o_valid, o_instr);
    end
    checks++;
    if (ctl !== {3'b000, 3'b000, 3'b010, 8'b0110_0000, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL addi_ctl got %b want %b", ctl,
               {3'b000, 3'b000, 3'b010, 8'b0110_0000, 2'b00, 2'b00});
    end
    tick();
    checks++;
    if ({o_valid, ctl} !== 22'h0) begin
      errors++;
      $display("FAIL addi_pop got valid=%b ctl=%h want 0 000000", o_valid, ctl);
    end
  endtask

  // Back-to-back stream: each cycle pushes a new word while popping the head.
  task automatic test_back_to_back();
    logic [31:0] ins [11];
    logic [20:0] exp [11];
    ins = '{32'h00012083, 32'h00A00093, 32'h0010009B, 32'h00008067, 32'h0000006F,
            32'h00112023, 32'h002081B3, 32'h002081BB, 32'h00208063, 32'h00000097,
            32'h000000B7};
    exp = '{{3'b000, 3'b001, 3'b000, 8'b0110_0011, 2'b00, 2'b00},   // lw
            {3'b000, 3'b000, 3'b010, 8'b0110_0000, 2'b00, 2'b00},   // addi
            {3'b000, 3'b000, 3'b011, 8'b0110_0000, 2'b00, 2'b00},   // addiw (XLEN=64)
            {3'b000, 3'b010, 3'b000, 8'b0110_1100, 2'b00, 2'b00},   // jalr
            {3'b011, 3'b010, 3'b000, 8'b0100_1000, 2'b00, 2'b00},   // jal
            {3'b001, 3'b000, 3'b000, 8'b1010_0010, 2'b00, 2'b00},   // sw
            {3'b000, 3'b000, 3'b010, 8'b0100_0000, 2'b00, 2'b00},   // add
            {3'b000, 3'b000, 3'b011, 8'b0100_0000, 2'b00, 2'b00},   // addw (XLEN=64)
            {3'b010, 3'b000, 3'b001, 8'b0001_0000, 2'b00, 2'b00},   // beq
            {3'b100, 3'b011, 3'b000, 8'b0100_0000, 2'b01, 2'b00},   // auipc
            {3'b100, 3'b100, 3'b000, 8'b0100_0000, 2'b10, 2'b00}};  // lui
    test_reset();
    ready = 1'b1; valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      instr = ins[i];
      tick();
      checks++;
      if ({o_valid, o_ready, o_instr, ctl} !== {1'b1, 1'b1, ins[i], exp[i]}) begin
        errors++;
        $display("FAIL b2b_%0d got valid=%b ready=%b instr=%h ctl=%b want 1 1 %h %b",
                 i, o_valid, o_ready, o_instr, ctl, ins[i], exp[i]);
      end
    end
    valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got valid=%b want 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    ready = 1'b0; valid = 1'b1;
    instr = 32'h00012083;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready1 got %b want 1", o_ready);
    end
    instr = 32'h00412103;
    tick();
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready2 got %b want 0", o_ready);
    end
    instr = 32'h00812183;   // third load, must be refused
    tick();
    checks++;
    if ({o_valid, o_ready, o_instr, o_result_src} !== {1'b1, 1'b0, 32'h00012083, 3'b001}) begin
      errors++;
      $display("FAIL bp_hold got valid=%b ready=%b instr=%h res=%b want 1 0 00012083 001",
               o_valid, o_ready, o_instr, o_result_src);
    end
    valid = 1'b0; ready = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_instr, o_result_src, o_load_instr} !== {1'b1, 32'h00412103, 3'b001, 1'b1}) begin
      errors++;
      $display("FAIL bp_pop2 got valid=%b instr=%h res=%b ld=%b want 1 00412103 001 1",
               o_valid, o_instr, o_result_src, o_load_instr);
    end
    tick();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_empty got valid/ready=%b want 01", {o_valid, o_ready});
    end
  endtask

  task automatic test_ecall();
    test_reset();
    ready = 1'b0; valid = 1'b1; instr = 32'h00000073;
    tick();
    instr = 32'h00A00093;   // addi offered during drain
    checks++;
    if ({o_valid, o_ready, o_trap, ctl[20:2]} !== {1'b1, 1'b0, 2'b01, 19'h0}) begin
      errors++;
      $display("FAIL ecall_head got valid=%b ready=%b trap=%b ctl=%h want 1 0 01 0",
               o_valid, o_ready, o_trap, ctl[20:2]);
    end
    tick();
    checks++;
    if ({o_instr, o_halted, o_ready} !== {32'h00000073, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ecall_block got instr=%h halted=%b ready=%b want 00000073 0 0",
               o_instr, o_halted, o_ready);
    end
    valid = 1'b0; ready = 1'b1;
    tick();
    checks++;
    if ({o_halted, o_valid, o_ready} !== 3'b100) begin
      errors++;
      $display("FAIL ecall_halt got halted/valid/ready=%b want 100", {o_halted, o_valid, o_ready});
    end
    tick();
    checks++;
    if (o_halted !== 1'b1) begin
      errors++;
      $display("FAIL ecall_stay got halted=%b want 1", o_halted);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({o_halted, o_valid, o_ready} !== 3'b001) begin
      errors++;
      $display("FAIL ecall_flush got halted/valid/ready=%b want 001", {o_halted, o_valid, o_ready});
    end
  endtask

  task automatic test_ebreak();
    test_reset();
    ready = 1'b1; valid = 1'b1; instr = 32'h00100073;
    tick();
    valid = 1'b0;
    checks++;
    if ({o_valid, o_trap, o_ready} !== {1'b1, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL ebreak_head got valid=%b trap=%b ready=%b want 1 10 0", o_valid, o_trap, o_ready);
    end
    tick();
    checks++;
    if ({o_halted, o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ebreak_halt got halted/valid=%b want 10", {o_halted, o_valid});
    end
  endtask

  task automatic test_illegal();
    test_reset();
    ready = 1'b0; valid = 1'b1; instr = 32'h0000007F;   // unlisted opcode
    tick();
    valid = 1'b0;
    checks++;
    if ({o_valid, ctl, o_ready} !== {1'b1, 21'h3, 1'b0}) begin
      errors++;
      $display("FAIL illegal_head got valid=%b ctl=%h ready=%b want 1 000003 0", o_valid, ctl, o_ready);
    end
    checks++;
    if ({w_trap, w_ready} !== 3'b111) begin
      errors++;
      $display("FAIL illegal_flag_only got trap=%b ready=%b want 11 1", w_trap, w_ready);
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({o_halted, w_halted} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_halt got halted=%b halted_w=%b want 1 0", o_halted, w_halted);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ready = 1'b0; valid = 1'b1; instr = 32'h00A00090;   // low bits 00
    tick();
    valid = 1'b0;
    checks++;
    if ({o_valid, ctl} !== {1'b1, 21'h3}) begin
      errors++;
      $display("FAIL illegal_lowbits got valid=%b ctl=%h want 1 000003", o_valid, ctl);
    end
  endtask

  task automatic test_xlen32();
    test_reset();
    ready = 1'b1; valid = 1'b1; instr = 32'h0010009B;   // addiw
    tick();
    valid = 1'b0;
    checks++;
    if ({w_valid, ctl_w} !== {1'b1, 21'h3}) begin
      errors++;
      $display("FAIL xlen32_addiw got valid=%b ctl=%h want 1 000003", w_valid, ctl_w);
    end
    checks++;
    if ({o_trap, o_alu_op, o_reg_we} !== {2'b00, 3'b011, 1'b1}) begin
      errors++;
      $display("FAIL xlen64_addiw got trap=%b alu=%b we=%b want 00 011 1", o_trap, o_alu_op, o_reg_we);
    end
    tick();
    checks++;
    if ({w_halted, w_ready, w_valid} !== 3'b010) begin
      errors++;
      $display("FAIL xlen32_nohalt got halted/ready/valid=%b want 010", {w_halted, w_ready, w_valid});
    end
  endtask

  task automatic test_csr();
    test_reset();
    ready = 1'b1; valid = 1'b1; instr = 32'h30529073;   // csrrw
    tick();
    valid = 1'b0;
`ifdef ZICSR_EN
    checks++;
    if ({o_valid, ctl} !== {1'b1, 3'b000, 3'b101, 3'b000, 8'b0100_0000, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL csr_dec got valid=%b ctl=%b want 1 %b", o_valid, ctl,
               {3'b000, 3'b101, 3'b000, 8'b0100_0000, 2'b00, 2'b00});
    end
    tick();
    checks++;
    if ({o_halted, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL csr_run got halted/ready=%b want 01", {o_halted, o_ready});
    end
`else
    checks++;
    if ({o_valid, ctl} !== {1'b1, 21'h3}) begin
      errors++;
      $display("FAIL csr_illegal got valid=%b ctl=%h want 1 000003", o_valid, ctl);
    end
    tick();
    checks++;
    if (o_halted !== 1'b1) begin
      errors++;
      $display("FAIL csr_halt got halted=%b want 1", o_halted);
    end
`endif
  endtask

  task automatic test_flush();
    test_reset();
    ready = 1'b0; valid = 1'b1;
    instr = 32'h00012083;
    tick();
    instr = 32'h00112023;
    tick();
    // Flush overrides the simultaneous push and pop.
    flush = 1'b1; ready = 1'b1; instr = 32'h00A00093;
    tick();
    flush = 1'b0;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_empty got valid/ready=%b want 01", {o_valid, o_ready});
    end
    instr = 32'h002081B3;
    tick();
    valid = 1'b0;
    checks++;
    if ({o_valid, o_instr} !== {1'b1, 32'h002081B3}) begin
      errors++;
      $display("FAIL flush_refill got valid=%b instr=%h want 1 002081b3", o_valid, o_instr);
    end
  endtask

  task automatic test_reset_mid_drain();
    test_reset();
    ready = 1'b0; valid = 1'b1; instr = 32'h00000073;
    tick();
    instr = 32'h00A00093;
    tick();
    rstn = 1'b0; valid = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if ({o_valid, o_halted, o_ready, o_trap} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_drain got valid/halted/ready/trap=%b want 00100",
               {o_valid, o_halted, o_ready, o_trap});
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_ecall();
    test_ebreak();
    test_illegal();
    test_xlen32();
    test_csr();
    test_flush();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
